rs_syndrome_atl: RTL

RS_SYNDROME_ATL -- requirements
Module: rs_syndrome_atl

---
 rtl/rs_atl_pkg.sv | 42 ++++
 rtl/gf_mult_const.sv | 34 +++
 rtl/rs_syndrome_atl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rs_atl_pkg.sv
// Shared definitions for the RS syndrome block: FSM encoding and GF(2^M) helpers.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package rs_atl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Widest field the helper functions can describe.
  localparam int GF_MAX_M = 16;

  // Multiply a field element by alpha (one LFSR step) for a field of width m.
  function automatic logic [GF_MAX_M-1:0] gf_xtime(input logic [GF_MAX_M-1:0] a,
                                                   input int m, input int irrpol);
    logic [GF_MAX_M:0] t;
    t = {a, 1'b0};
    if (t[m]) t = t ^ (GF_MAX_M+1)'(irrpol);
    return t[GF_MAX_M-1:0];
  endfunction

  // Alpha-power table entry: alpha^k in the field generated by irrpol.
  function automatic logic [GF_MAX_M-1:0] gf_alpha_pow(input int k, input int m,
                                                       input int irrpol);
    logic [GF_MAX_M-1:0] v;
    int order;
    int e;
    order = (1 << m) - 1;
    e     = k % order;
    v     = GF_MAX_M'(1);
    for (int j = 0; j < e; j++) v = gf_xtime(v, m, irrpol);
    return v;
  endfunction

  // Exponent of the i-th generator root.
  function automatic int root_exp(input int i, input int genstart, input int rootspace);
    return genstart + i * rootspace;
  endfunction

endpackage

// File: rtl/gf_mult_const.sv
// Multiplies a GF(2^M) symbol by the fixed constant alpha^K.
// Latency: combinational.
// Backpressure: none (pure datapath).
module gf_mult_const
  import rs_atl_pkg::*;
#(
  parameter int M      = 4,
  parameter int IRRPOL = 19,
  parameter int K      = 0
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  localparam logic [GF_MAX_M-1:0] C_FULL = gf_alpha_pow(K, M, IRRPOL);
  localparam logic [M-1:0]        C      = C_FULL[M-1:0];
  localparam logic [GF_MAX_M-1:0] P_FULL = GF_MAX_M'(IRRPOL);
  localparam logic [M-1:0]        POLY   = P_FULL[M-1:0];

  logic [M-1:0] shf;
  logic [M-1:0] prod;

  // Shift-and-add against the constant, reducing the shifted operand each step.
  always_comb begin
    prod = '0;
    shf  = a;
    for (int j = 0; j < M; j++) begin
      if (C[j]) prod = prod ^ shf;
      shf = {shf[M-2:0], 1'b0} ^ (shf[M-1] ? POLY : '0);
    end
    y = prod;
  end

endmodule

// File: rtl/rs_syndrome_atl.sv
// Streaming RS syndrome calculator: Horner accumulation of up to CHECK syndromes per block.
// Latency: syn_val one cycle after the eop symbol is accepted.
// Backpressure: sink_ena drops while a result is held; held until source_ena=1.
module rs_syndrome_atl
  import rs_atl_pkg::*;
#(
  parameter int CHECK     = 6,
  parameter int M         = 4,
  parameter int IRRPOL    = 19,
  parameter int GENSTART  = 0,
  parameter int ROOTSPACE = 1,
  parameter int WIDE      = 3
) (
  input  logic               clk_int,
  input  logic               reset_int,
  input  logic               sink_val,
  input  logic               sink_sop,
  input  logic               sink_eop,
  input  logic [M-1:0]       rsin,
  input  logic [WIDE-1:0]    numcheck,
  output logic               sink_ena,
  input  logic               source_ena,
  output logic               syn_val,
  output logic [CHECK*M-1:0] syn,
  output logic               err_flag,
  output logic               proto_err
);

  // Count value of the 14th symbol for M=4: one more non-eop symbol overruns a codeword.
  localparam logic [M-1:0] CNT_LAST = {M{1'b1}} - M'(1);

  state_t          state, state_nxt;
  logic            accept;
  logic            do_load, do_step, do_clear, perr_nxt;
  logic [WIDE-1:0] nc_in, nc_lat;
  logic [CHECK-1:0] mask_in, mask_lat;
  logic [M-1:0]    count;
  logic [M-1:0]    acc [CHECK];
  logic [M-1:0]    mul [CHECK];

  assign accept = sink_val & sink_ena;

  // Out-of-range check counts fall back to the full CHECK syndromes.
  always_comb begin
    nc_in = numcheck;
    if (numcheck == '0 || int'(numcheck) > CHECK) nc_in = WIDE'(CHECK);
  end

  // Per-syndrome enables for the incoming and the latched check count.
  always_comb begin
    mask_in  = '0;
    mask_lat = '0;
    for (int i = 0; i < CHECK; i++) begin
      mask_in[i]  = (i < int'(nc_in));
      mask_lat[i] = (i < int'(nc_lat));
    end
  end

  for (genvar g = 0; g < CHECK; g++) begin : g_root
    gf_mult_const #(
      .M      (M),
      .IRRPOL (IRRPOL),
      .K      (root_exp(g, GENSTART, ROOTSPACE))
    ) u_mult (
      .a (acc[g]),
      .y (mul[g])
    );
  end

  // Next-state and datapath controls from the framing of the accepted symbol.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    do_clear  = 1'b0;
    perr_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (sink_sop) begin
            do_load   = 1'b1;
            state_nxt = sink_eop ? ST_HOLD : ST_ACCUM;
          end else begin
            perr_nxt = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          if (sink_sop) begin
            perr_nxt  = 1'b1;
            do_load   = 1'b1;
            state_nxt = sink_eop ? ST_HOLD : ST_ACCUM;
          end else if (sink_eop) begin
            do_step   = 1'b1;
            state_nxt = ST_HOLD;
          end else if (count == CNT_LAST) begin
            perr_nxt  = 1'b1;
            do_clear  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            do_step = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (source_ena) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_int or negedge reset_int) begin
    if (!reset_int) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Registered handshake/status outputs, check-count latch and symbol counter.
  always_ff @(posedge clk_int or negedge reset_int) begin
    if (!reset_int) begin
      sink_ena  <= 1'b0;
      syn_val   <= 1'b0;
      proto_err <= 1'b0;
      nc_lat    <= '0;
      count     <= '0;
    end else begin
      sink_ena  <= (state_nxt != ST_HOLD);
      syn_val   <= (state_nxt == ST_HOLD);
      proto_err <= perr_nxt;
      if (do_load) begin
        nc_lat <= nc_in;
        count  <= M'(1);
      end else if (do_step) begin
        count <= count + M'(1);
      end else if (do_clear) begin
        count <= '0;
      end
    end
  end

  // Syndrome accumulators: load on sop, Horner step otherwise, unused slots forced to zero.
  always_ff @(posedge clk_int or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < CHECK; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < CHECK; i++) begin
        if (do_load)       acc[i] <= mask_in[i]  ? rsin : '0;
        else if (do_step)  acc[i] <= mask_lat[i] ? (mul[i] ^ rsin) : '0;
        else if (do_clear) acc[i] <= '0;
      end
    end
  end

  // Pack S0 at the bottom of the result bus.
  always_comb begin
    syn = '0;
    for (int i = 0; i < CHECK; i++) syn[i*M +: M] = acc[i];
  end

  assign err_flag = |syn;

endmodule
